pointwise_mul_stream: RTL and testbench

- Parametrised successor to the single-lane, combinational, constant-by-2 pointwise multiplier.
- Multiplies each lane of an incoming pixel vector by a runtime-loadable unsigned coefficient. Results pass through a STAGES-deep pipeline with valid/ready backpressure on both sides.
- Sits between a line-buffer/stencil producer and the next pointwise or reduction stage in generated accelerator tops.
- Carries a frame-end tag (last) and counts completed output transfers.

---
 rtl/pointwise_mul_stream.sv | 113 +++++++++++
 tb/tb_pointwise_mul_stream.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pointwise_mul_stream.sv
// Per-lane unsigned multiply by a loadable coefficient; POINTWISE_MUL_SAT_EN selects saturation over wrap.
// Latency: STAGES-1 cycles from accept edge to visible output; one transfer per cycle.
// Backpressure: combinational ready chain; any empty slot downstream keeps in_ready high.
module pointwise_mul_stream #(
    parameter int WIDTH      = 16,
    parameter int LANES      = 1,
    parameter int STAGES     = 2,
    parameter int COEFF_INIT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       coeff_data,
    input  logic                   coeff_load,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [31:0]            out_count
);

`ifdef POINTWISE_MUL_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int PW = 2 * WIDTH;
    localparam int DW = LANES * PW;

    logic [WIDTH-1:0]  coeff;
    logic [DW-1:0]     prod;
    logic [DW-1:0]     slot_dat [STAGES];
    logic [STAGES-1:0] slot_vld;
    logic [STAGES-1:0] slot_last;
    logic [STAGES-1:0] rdy;

    // Slot k can take new contents if it or any slot after it is empty, or the sink is taking.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!slot_vld[j]) begin
                    rdy[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        prod = '0;
        for (int i = 0; i < LANES; i++) begin
            prod[i*PW +: PW] = PW'(in_data[i*WIDTH +: WIDTH]) * PW'(coeff);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coeff     <= WIDTH'(COEFF_INIT);
            slot_vld  <= '0;
            slot_last <= '0;
            out_count <= '0;
            for (int k = 0; k < STAGES; k++) begin
                slot_dat[k] <= '0;
            end
        end else begin
            if (coeff_load) begin
                coeff <= coeff_data;
            end
            if (out_valid && out_ready) begin
                out_count <= out_count + 32'd1;
            end
            if (rdy[0]) begin
                slot_vld[0]  <= in_valid;
                slot_last[0] <= in_valid & in_last;
                if (in_valid) begin
                    slot_dat[0] <= prod;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    slot_vld[k]  <= slot_vld[k-1];
                    slot_last[k] <= slot_vld[k-1] & slot_last[k-1];
                    if (slot_vld[k-1]) begin
                        slot_dat[k] <= slot_dat[k-1];
                    end
                end
            end
        end
    end

    // Width reduction happens on the way out of the final slot.
    always_comb begin
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        lo       = '0;
        hi       = '0;
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            lo = slot_dat[STAGES-1][i*PW +: WIDTH];
            hi = slot_dat[STAGES-1][i*PW+WIDTH +: WIDTH];
            out_data[i*WIDTH +: WIDTH] = (SAT_EN && (hi != '0)) ? {WIDTH{1'b1}} : lo;
        end
    end

    assign out_valid = slot_vld[STAGES-1];
    assign out_last  = slot_vld[STAGES-1] & slot_last[STAGES-1];
    assign in_ready  = !reset && rdy[0];

endmodule

// File: tb/tb_pointwise_mul_stream.sv
// Bench for pointwise_mul_stream with LANES=4, STAGES=2: scoreboard model plus directed literal checks.
module tb_pointwise_mul_stream;

    localparam int W = 16;
    localparam int L = 4;
    localparam int S = 2;

    logic          clk;
    logic          reset;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [15:0]   coeff_data;
    logic          coeff_load;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;
    logic [31:0]   out_count;

    pointwise_mul_stream #(.WIDTH(W), .LANES(L), .STAGES(S), .COEFF_INIT(2)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .coeff_data(coeff_data), .coeff_load(coeff_load),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .out_count(out_count)
    );

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          t;
        int          st;
    } exp_t;

    exp_t        q[$];
    logic [63:0] olog[$];
    logic        llog[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          stall = 0;
    int          acc = 0;
    int          cnt = 0;
    logic [15:0] cm = 16'd2;
    logic        post_rst = 1'b0;
    logic        hold = 1'b0;
    logic [63:0] hd;
    logic        hl;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] d, input logic [15:0] c);
        logic [63:0] r;
        int unsigned p;
        r = '0;
        for (int i = 0; i < L; i++) begin
            p = int'(d[i*16 +: 16]) * int'(c);
`ifdef POINTWISE_MUL_SAT_EN
            r[i*16 +: 16] = (p > 65535) ? 16'hFFFF : 16'(p);
`else
            r[i*16 +: 16] = 16'(p % 65536);
`endif
        end
        return r;
    endfunction

    // Everything below observes the values that will be sampled at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("in_ready_in_reset", in_ready, 0);
            q.delete();
            cm = 16'd2;
            cnt = 0;
            post_rst = 1'b1;
            hold = 1'b0;
        end else begin
            if (post_rst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_in_ready", in_ready, 1);
                post_rst = 1'b0;
            end
            chk("out_count", out_count, cnt);
            if (!out_valid) chk("out_last_idle", out_last, 0);
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_last", out_last, hl);
            end
            if (!out_ready) stall++;
            if (in_valid && in_ready) begin
                q.push_back('{model(in_data, cm), in_last, cyc, stall});
                acc++;
            end
            if (coeff_load) cm = coeff_data;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_last", out_last, e.l);
                    if (e.st == stall) chk("latency", cyc - e.t, S);
                end
                cnt++;
                olog.push_back(out_data);
                llog.push_back(out_last);
            end
            hold = out_valid && !out_ready;
            hd = out_data;
            hl = out_last;
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic cl, input logic [15:0] cd);
        bit done;
        done = 1'b0;
        in_data = d; in_valid = 1'b1; in_last = l; coeff_load = cl; coeff_data = cd;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0; in_last = 1'b0; coeff_load = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        in_valid = 1'b0; coeff_load = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 200 && !empty; n++) begin
            @(negedge clk); #1;
            if (q.size() == 0 && !out_valid) empty = 1'b1;
        end
        chk("drain_empty", empty, 1);
        @(posedge clk); #1;
    endtask

    task automatic load_coeff(input logic [15:0] c);
        coeff_load = 1'b1; coeff_data = c;
        @(posedge clk); #1;
        coeff_load = 1'b0;
    endtask

    initial begin
        int a0;
        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        coeff_load = 1'b0; coeff_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Counting stream with default coefficient.
        olog.delete();
        for (int i = 0; i < 100; i++)
            send({16'(i + 3), 16'(i + 2), 16'(i + 1), 16'(i)}, 1'b0, 1'b0, 16'd0);
        drain();
        chk("stream_count", out_count, 100);
        chk("stream_len", olog.size(), 100);
        for (int i = 0; i < 100 && i < olog.size(); i++)
            chk("stream_val", olog[i][15:0], 16'(2 * i));

        // Overflowing product.
        olog.delete();
        send(64'h0000_0000_0000_9000, 1'b0, 1'b0, 16'd0);
        drain();
`ifdef POINTWISE_MUL_SAT_EN
        chk("ovf_lane0", olog[0][15:0], 16'hFFFF);
`else
        chk("ovf_lane0", olog[0][15:0], 16'h2000);
`endif

        // Backpressure from an empty pipeline.
        out_ready = 1'b0; in_valid = 1'b1; a0 = acc;
        for (int i = 0; i < 10; i++) begin
            in_data = {4{16'(100 + i)}};
            @(posedge clk); #1;
        end
        chk("bp_accepts", acc - a0, S);
        chk("bp_in_ready", in_ready, 0);
        olog.delete();
        drain();
        chk("bp_len", olog.size(), 2);
        chk("bp_first", olog[0][15:0], 16'd200);
        chk("bp_second", olog[1][15:0], 16'd202);

        // Coefficient change on the accept edge of element 7.
        olog.delete();
        send(64'd7, 1'b0, 1'b1, 16'd5);
        send(64'd8, 1'b0, 1'b0, 16'd0);
        drain();
        chk("coeff_old", olog[0][15:0], 16'd14);
        chk("coeff_new", olog[1][15:0], 16'd40);

        // Multi-lane with last on the third element.
        load_coeff(16'd3);
        olog.delete(); llog.delete();
        for (int i = 0; i < 3; i++)
            send(64'h0004_0003_0002_0001, (i == 2), 1'b0, 16'd0);
        drain();
        chk("lanes_val", olog[0], 64'h000C_0009_0006_0003);
        chk("last_0", llog[0], 0);
        chk("last_1", llog[1], 0);
        chk("last_2", llog[2], 1);

        // Reset with elements in flight.
        load_coeff(16'd9);
        out_ready = 1'b0;
        send(64'd11, 1'b0, 1'b0, 16'd0);
        send(64'd12, 1'b0, 1'b0, 16'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        olog.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("rst_no_output", olog.size(), 0);
        chk("rst_count", out_count, 0);
        send(64'd5, 1'b0, 1'b0, 16'd0);
        drain();
        chk("rst_coeff", olog[0][15:0], 16'd10);

        // Randomised traffic with one mid-stream reset.
        for (int n = 0; n < 3000; n++) begin
            in_valid   = ($urandom % 3) != 0;
            in_data    = {16'($urandom), 16'($urandom % 256), 16'($urandom % 4096), 16'($urandom)};
            in_last    = ($urandom % 8) == 0;
            coeff_load = ($urandom % 20) == 0;
            coeff_data = ($urandom % 2) ? 16'($urandom % 16) : 16'($urandom);
            out_ready  = ($urandom % 4) != 0;
            reset      = (n == 1500);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        drain();
        chk("final_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
